// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule: state encoding, sizes and round constants.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned NUM_WORDS  = 44;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StReady
    } state_e;

    // Rcon top byte indexed by i/4; entry 0 is never used by the expansion.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 == x^-1 for nonzero x and maps 0 to 0; built as x^2 * x^4 * ... * x^128.
    always_comb begin
        inv = 8'h01;
        sq  = in_i;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key expansion: loads a cipher key, expands one word per cycle into 44 stored words,
// and serves any of the 11 round keys combinationally.
module aes_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_idx,
    output logic [127:0] round_key,
    output logic         key_ready,
    output logic         busy
);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        ready_q;
    logic [31:0] w_q [NUM_WORDS];

    logic [31:0] w_prev;
    logic [31:0] w_back4;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] t;
    logic [31:0] w_new;
    logic [5:0]  base;

    assign rot = {w_prev[23:0], w_prev[31:24]};

    for (genvar b = 0; b < 4; b++) begin : gen_sbox
        aes_sbox u_sbox (
            .in_i  (rot[8*b +: 8]),
            .out_o (sub[8*b +: 8])
        );
    end

    always_comb begin
        w_prev  = w_q[cnt_q - 6'd1];
        w_back4 = w_q[cnt_q - 6'd4];
        if (cnt_q[1:0] == 2'b00) begin
            t = sub ^ {rcon(cnt_q[5:2]), 24'h000000};
        end else begin
            t = w_prev;
        end
        w_new = w_back4 ^ t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (key_load) begin
            state_q <= StExpand;
            cnt_q   <= 6'd4;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StExpand: begin
                    if (cnt_q == 6'(NUM_WORDS - 1)) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                w_q[i] <= 32'h0;
            end
        end else if (key_load) begin
            w_q[0] <= key_in[127:96];
            w_q[1] <= key_in[95:64];
            w_q[2] <= key_in[63:32];
            w_q[3] <= key_in[31:0];
        end else if (state_q == StExpand) begin
            w_q[cnt_q] <= w_new;
        end
    end

    always_comb begin
        base      = {round_idx, 2'b00};
        round_key = 128'h0;
        if (round_idx <= 4'(NUM_ROUNDS)) begin
            round_key = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        end
    end

    assign busy      = busy_q;
    assign key_ready = ready_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: word-level key-expansion model plus FIPS-197 vectors.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         key_ready;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;

    aes_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .round_idx (round_idx),
        .round_key (round_key),
        .key_ready (key_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] aa  = a;
        logic [7:0] bb  = b;
        while (bb != 8'h00) begin
            if (bb[0]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    // Word i is packed at bits [(43-i)*32 +: 32], so round r sits at [(10-r)*128 +: 128].
    function automatic logic [44*32-1:0] expand_key(input logic [127:0] k);
        logic [31:0]        w [44];
        logic [31:0]        tmp;
        logic [7:0]         rc;
        logic [44*32-1:0]   packed_w;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) packed_w[(43-i)*32 +: 32] = w[i];
        return packed_w;
    endfunction

    logic [44*32-1:0] m_words;
    logic             m_busy;
    logic             m_ready;
    logic             m_zero;
    int               m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_zero  <= 1'b1;
            m_left  <= 0;
            m_words <= '0;
        end else if (key_load) begin
            m_words <= expand_key(key_in);
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_zero  <= 1'b0;
            m_left  <= 40;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 128'(busy), 128'(m_busy));
        chk("key_ready", 128'(key_ready), 128'(m_ready));
        if (m_ready) begin
            if (round_idx <= 4'd10) begin
                chk("round_key", round_key, m_words[(10 - int'(round_idx))*128 +: 128]);
            end else begin
                chk("round_key_oor", round_key, 128'h0);
            end
        end else if (m_zero) begin
            chk("round_key_cleared", round_key, 128'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(posedge clk);
        #1 key_load = 1'b0;
    endtask

    // Called just after the edge that sampled key_load.
    task automatic wait_ready(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (key_ready) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) $display("FAIL wait_ready: timed out after 60 cycles, required 40");
    endtask

    task automatic check_idx(input string nm, input logic [3:0] idx, input logic [127:0] exp);
        round_idx = idx;
        #1 chk(nm, round_key, exp);
    endtask

    int lat;
    int bcnt;

    initial begin
        key_load  = 1'b0;
        key_in    = '0;
        round_idx = 4'd0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_key_ready", 128'(key_ready), 128'h0);
        chk("reset_round_key", round_key, 128'h0);
        repeat (3) @(posedge clk);
        #1;

        // FIPS-197 expansion
        load(FipsKey);
        wait_ready(lat, bcnt);
        chk("fips_latency", 128'(lat), 128'd40);
        chk("fips_busy_cycles", 128'(bcnt), 128'd40);
        check_idx("fips_r1", 4'd1, FipsR1);
        check_idx("fips_r10", 4'd10, FipsR10);
        check_idx("oor_11", 4'd11, 128'h0);
        check_idx("oor_15", 4'd15, 128'h0);
        check_idx("r0_is_key", 4'd0, FipsKey);
        repeat (5) @(posedge clk);
        #1 check_idx("ready_held_r10", 4'd10, FipsR10);

        // Restart 15 cycles into an unrelated expansion
        load(128'h00112233445566778899aabbccddeeff);
        repeat (14) @(posedge clk);
        #1;
        load(FipsKey);
        wait_ready(lat, bcnt);
        chk("restart_latency", 128'(lat), 128'd40);
        check_idx("restart_r10", 4'd10, FipsR10);

        // Reload from READY with the all-zero key
        load(128'h0);
        chk("reload_ready_drop", 128'(key_ready), 128'h0);
        chk("reload_busy", 128'(busy), 128'h1);
        wait_ready(lat, bcnt);
        chk("zero_latency", 128'(lat), 128'd40);
        chk("zero_busy_cycles", 128'(bcnt), 128'd40);
        check_idx("zero_r1", 4'd1, ZeroR1);

        // Asynchronous reset 20 cycles into expansion
        load(FipsKey);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 128'(busy), 128'h0);
        chk("async_rst_key_ready", 128'(key_ready), 128'h0);
        chk("async_rst_round_key", round_key, 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", 128'(busy), 128'h0);
        chk("post_rst_idle_ready", 128'(key_ready), 128'h0);
        load(FipsKey);
        wait_ready(lat, bcnt);
        chk("post_rst_latency", 128'(lat), 128'd40);
        check_idx("post_rst_r1", 4'd1, FipsR1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
